// File: rtl/popcount_pkg.sv
// Shared constants and helpers for the 32-input popcount datapath.
package popcount_pkg;

    localparam int unsigned POP_WORD_W  = 32;
    localparam int unsigned POP_CNT_W   = 6;
    localparam int unsigned POP_CNT_MAX = 32;

    // Ones-count of one 32-bit word (0..32).
    typedef logic [POP_CNT_W-1:0] pop_cnt_t;

    // Accumulator width that holds POP_CNT_MAX * frame_len without overflow.
    function automatic int unsigned acc_width(input int unsigned frame_len);
        return $clog2(POP_CNT_MAX * frame_len + 1);
    endfunction

endpackage

// File: rtl/popcount_out_reg.sv
// One-entry result register with valid/ready handshake.
// A load always wins over a consume in the same cycle, so close+consume
// back-to-back keeps out_valid_o high with no gap.
module popcount_out_reg
    import popcount_pkg::*;
#(
    parameter int unsigned ACC_W = 10,
    parameter int unsigned WC_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [ACC_W-1:0] load_sum_i,
    input  logic [WC_W-1:0]  load_words_i,
    input  logic             load_over_i,
    output logic             load_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_sum_o,
    output logic [WC_W-1:0]  out_words_o,
    output logic             out_over_o
);

    logic             valid_q, valid_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [WC_W-1:0]  words_q, words_d;
    logic             over_q, over_d;
    logic             consume;

    // Register is free when empty or being drained this cycle.
    always_comb begin
        consume      = valid_q && out_ready_i;
        load_ready_o = !valid_q || out_ready_i;
    end

    // Load/consume arbitration; payload only changes on a load.
    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        words_d = words_q;
        over_d  = over_q;
        if (load_i) begin
            valid_d = 1'b1;
            sum_d   = load_sum_i;
            words_d = load_words_i;
            over_d  = load_over_i;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    // Result state; a pending result is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            words_q <= '0;
            over_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            words_q <= words_d;
            over_q  <= over_d;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        out_valid_o = valid_q;
        out_sum_o   = sum_q;
        out_words_o = words_q;
        out_over_o  = over_q;
    end

endmodule

// File: rtl/popcount_frame_accumulator.sv
// Sums per-word popcounts over a frame and publishes frame total, word
// count and threshold flag through a one-entry output register.
module popcount_frame_accumulator
    import popcount_pkg::*;
#(
    parameter int unsigned CNT_W     = POP_CNT_W,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned ACC_W     = acc_width(FRAME_LEN),
    parameter int unsigned WC_W      = $clog2(FRAME_LEN + 1),
    parameter int unsigned THRESH    = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [WC_W-1:0]  out_words,
    output logic             out_over,
    output logic             err_range
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             err_q, err_d;

    logic             accept;
    logic             close;
    logic             over_range;
    pop_cnt_t         cnt_clamped;
    logic [ACC_W-1:0] sum_next;
    logic [WC_W-1:0]  words_next;
    logic             over_next;
    logic             load_ready;

    // Clamp, frame-close detection and the running sum including this word.
    always_comb begin
        accept      = in_valid && in_ready;
        over_range  = in_count > CNT_W'(POP_CNT_MAX);
        cnt_clamped = over_range ? pop_cnt_t'(POP_CNT_MAX) : pop_cnt_t'(in_count);
        sum_next    = acc_q + ACC_W'(cnt_clamped);
        words_next  = wcnt_q + WC_W'(1);
        // in_last on the last slot of a full frame still closes just once.
        close       = accept && (in_last || (wcnt_q == WC_W'(FRAME_LEN - 1)));
        over_next   = 32'(sum_next) >= THRESH;
    end

    // Accumulator, word counter and sticky range error next-state.
    always_comb begin
        acc_d  = acc_q;
        wcnt_d = wcnt_q;
        err_d  = err_q || (accept && over_range);
        if (close) begin
            acc_d  = '0;
            wcnt_d = '0;
        end else if (accept) begin
            acc_d  = sum_next;
            wcnt_d = words_next;
        end
    end

    // Frame state; a partial frame is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    // Input stalls whenever the result register cannot take a new frame.
    always_comb begin
        in_ready  = load_ready;
        err_range = err_q;
    end

    popcount_out_reg #(
        .ACC_W (ACC_W),
        .WC_W  (WC_W)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (close),
        .load_sum_i   (sum_next),
        .load_words_i (words_next),
        .load_over_i  (over_next),
        .load_ready_o (load_ready),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_sum_o    (out_sum),
        .out_words_o  (out_words),
        .out_over_o   (out_over)
    );

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Self-checking bench for popcount_frame_accumulator: table of frames plus
// hand-written corner sequences, results checked through a scoreboard queue.
module tb_popcount_frame_accumulator;

    localparam int unsigned CNT_W     = 6;
    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned ACC_W     = 10;
    localparam int unsigned WC_W      = 5;
    localparam int unsigned THRESH    = 256;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CNT_W-1:0] in_count = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [WC_W-1:0]  out_words;
    logic             out_over;
    logic             err_range;

    always #5 clk = ~clk;

    popcount_frame_accumulator #(
        .CNT_W     (CNT_W),
        .FRAME_LEN (FRAME_LEN),
        .ACC_W     (ACC_W),
        .WC_W      (WC_W),
        .THRESH    (THRESH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_words (out_words),
        .out_over  (out_over),
        .err_range (err_range)
    );

    typedef struct {
        int unsigned sum;
        int unsigned words;
        bit          over;
    } res_t;

    typedef struct {
        int unsigned n;
        int unsigned c0;
        int unsigned step;
        bit          last;
        int unsigned exp_sum;
        int unsigned exp_words;
        bit          exp_over;
    } frame_vec_t;

    res_t       sb_q[$];
    res_t       mon_exp;
    frame_vec_t vecs[9];
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t mk_res(input int unsigned s, input int unsigned w, input bit o);
        res_t r;
        r.sum   = s;
        r.words = w;
        r.over  = o;
        return r;
    endfunction

    // Scoreboard: compare the payload on every consume.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got sum %0d words %0d, expected none",
                         out_sum, out_words);
            end else begin
                mon_exp = sb_q.pop_front();
                check("result_sum", 32'(out_sum), mon_exp.sum);
                check("result_words", 32'(out_words), mon_exp.words);
                check("result_over", 32'(out_over), 32'(mon_exp.over));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_word(input int unsigned c, input bit last, input bit no_stall);
        int unsigned waited = 0;
        in_valid = 1'b1;
        in_count = CNT_W'(c);
        in_last  = last;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", waited);
        end
        if (no_stall) check("no_bubble", waited, 0);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input frame_vec_t v);
        for (int i = 0; i < int'(v.n); i++) begin
            if (i == int'(v.n) - 1) sb_q.push_back(mk_res(v.exp_sum, v.exp_words, v.exp_over));
            send_word(v.c0 + v.step * i, v.last && (i == int'(v.n) - 1), 1'b1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_sum"}, 32'(out_sum), 0);
        check({tag, "_out_words"}, 32'(out_words), 0);
        check({tag, "_out_over"}, 32'(out_over), 0);
        check({tag, "_err_range"}, 32'(err_range), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // n, c0, step, last -> sum, words, over
        vecs[0] = '{16, 32, 0, 1'b0, 512, 16, 1'b1};
        vecs[1] = '{3, 5, 1, 1'b1, 18, 3, 1'b0};
        vecs[2] = '{1, 20, 0, 1'b1, 20, 1, 1'b0};
        vecs[3] = '{16, 16, 0, 1'b0, 256, 16, 1'b1};
        vecs[4] = '{16, 16, 0, 1'b0, 256, 16, 1'b1};
        vecs[5] = '{16, 15, 0, 1'b0, 240, 16, 1'b0};
        vecs[6] = '{16, 1, 0, 1'b1, 16, 16, 1'b0};
        vecs[7] = '{5, 0, 0, 1'b1, 0, 5, 1'b0};
        vecs[8] = '{4, 29, 1, 1'b1, 122, 4, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 1);

        // Table of frames, consumer always ready, back-to-back.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send_frame(vecs[i]);
        repeat (3) idle();
        check("table_drained", sb_q.size(), 0);
        check("table_err_range", 32'(err_range), 0);

        // One-cycle latency on a one-word frame.
        sb_q.push_back(mk_res(9, 1, 1'b0));
        send_word(9, 1'b1, 1'b1);
        in_valid = 1'b0;
        check("latency_out_valid", 32'(out_valid), 1);
        repeat (2) idle();
        check("consumed_out_valid", 32'(out_valid), 0);

        // Backpressure hold, then close coinciding with consume.
        out_ready = 1'b0;
        sb_q.push_back(mk_res(30, 3, 1'b0));
        send_word(10, 1'b0, 1'b1);
        send_word(10, 1'b0, 1'b1);
        send_word(10, 1'b1, 1'b1);
        in_valid = 1'b1;
        in_count = CNT_W'(3);
        in_last  = 1'b1;
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_in_ready", 32'(in_ready), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_sum", 32'(out_sum), 30);
            check("bp_hold_words", 32'(out_words), 3);
            check("bp_hold_in_ready", 32'(in_ready), 0);
        end
        sb_q.push_back(mk_res(3, 1, 1'b0));
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("reload_out_valid", 32'(out_valid), 1);
        check("reload_out_sum", 32'(out_sum), 3);
        repeat (2) idle();
        check("bp_drained", sb_q.size(), 0);

        // Out-of-range counts clamp to 32; err_range is sticky until reset.
        sb_q.push_back(mk_res(64, 2, 1'b0));
        send_word(40, 1'b0, 1'b1);
        send_word(40, 1'b1, 1'b1);
        idle();
        check("err_set", 32'(err_range), 1);
        sb_q.push_back(mk_res(10, 2, 1'b0));
        send_word(5, 1'b0, 1'b1);
        send_word(5, 1'b1, 1'b1);
        repeat (2) idle();
        check("err_sticky", 32'(err_range), 1);
        rst_n = 1'b0;
        #1;
        check("err_cleared", 32'(err_range), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a frame discards it.
        for (int k = 0; k < 7; k++) send_word(3, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame('{16, 1, 0, 1'b0, 16, 16, 1'b0});
        repeat (3) idle();
        check("final_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/popcount_frame_accumulator.md
# popcount_frame_accumulator

Downstream stage of the 32-input population counter. It consumes one 6-bit ones-count per cycle over a valid/ready handshake and sums the counts over a frame of words. At frame close it publishes the frame total, the word count and a threshold flag through a one-entry output register with backpressure. A single block therefore turns per-word popcounts into per-frame weights for the decision logic that follows.

## Interface
- `CNT_W`, 6: width of the incoming count; legal values are 0..32.
- `FRAME_LEN`, 16: number of words in a full frame; must be at least 2.
- `ACC_W`, $clog2(32*FRAME_LEN+1): accumulator and result width; 10 with the defaults.
- `WC_W`, $clog2(FRAME_LEN+1): width of the word counter.
- `THRESH`, 256: the `out_over` flag compares the frame sum against this value.
- `clk` in 1: the single clock; everything is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `in_count` is valid this cycle.
- `in_ready` out 1: the block can accept a word this cycle.
- `in_count` in CNT_W: ones-count of one 32-bit word.
- `in_last` in 1: closes the frame early on this word.
- `out_valid` out 1: the result register holds an unconsumed frame.
- `out_ready` in 1: the consumer accepts the result.
- `out_sum` out ACC_W: sum of the counts in the frame.
- `out_words` out WC_W: number of words in the frame, 1..FRAME_LEN.
- `out_over` out 1: high when `out_sum` >= THRESH.
- `err_range` out 1: sticky flag; set when any accepted count exceeded 32.

## Operation
**Handshakes**
- A word is accepted on a cycle with `in_valid && in_ready`.
- A result is consumed on a cycle with `out_valid && out_ready`.

**Input clamping**
- An accepted `in_count` greater than 32 is clamped to 32 before accumulation.
- The same acceptance sets `err_range`, which stays set until reset.

**States**
- ACCUM: collecting a frame. It holds `acc` (width ACC_W) and `wcnt` (width WC_W).
- CLOSE condition: the accepted word has `in_last`, or `wcnt == FRAME_LEN-1`.

**Transitions**
- Accepted word without CLOSE:
  - `acc <= acc + clamp(in_count)`
  - `wcnt <= wcnt + 1`
  - the block stays in ACCUM.
- Accepted word with CLOSE:
  - `out_sum <= acc + clamp(in_count)`
  - `out_words <= wcnt + 1`
  - `out_over <= (out_sum next >= THRESH)`
  - `out_valid <= 1`
  - `acc <= 0`, `wcnt <= 0`
  - the next frame starts on the following cycle.
- `in_last` on the first word of a frame closes a one-word frame, with `out_words` = 1.
- A full frame with `in_last` also asserted closes once; the two conditions are not double-counted.

**Backpressure**
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready` and registered state only; it never depends on `in_valid`.
- Input therefore stalls while an unconsumed result is held, even mid-frame.

**Output register**
- On a consume without a simultaneous CLOSE: `out_valid <= 0`.
- On a consume with a simultaneous CLOSE: the register is reloaded with the new frame and `out_valid` stays 1.
- `out_sum`, `out_words` and `out_over` hold stable while `out_valid && !out_ready`.

**Arithmetic**
- Unsigned throughout.
- ACC_W is sized so the maximum sum, 32*FRAME_LEN, never overflows.
- No saturation logic is required.

## Timing
**Reset**
- `rst_n` low asynchronously clears `acc`, `wcnt`, `out_valid`, `out_sum`, `out_words`, `out_over` and `err_range` to 0.
- `in_ready` reads 1 during reset and after release.
- A partial frame in progress when reset asserts is discarded and never emitted.
- A pending result is dropped.

**Latency**
- `out_valid` rises on the rising edge that accepts the closing word, i.e. one cycle of latency.

**Throughput**
- One word per cycle.
- Back-to-back full frames run with zero bubbles while `out_ready` is held at 1.

**Boundary conditions**
- `in_valid` low mid-frame: `acc` and `wcnt` hold indefinitely.
- `out_ready` asserted while `out_valid` is low: no effect.

## Structure
**Shared package `popcount_pkg`**
- Constants `POP_WORD_W` = 32 and `POP_CNT_W` = 6.
- `POP_CNT_MAX` = 32.
- A typedef for the 6-bit count.
- The `ACC_W` derivation as a function of frame length.

**Sub-module `popcount_out_reg`**
- One sub-module: the one-entry output register with its valid/ready handshake.
- It owns `out_valid`, the result payload and the load/consume arbitration.

**Top level**
- The top level holds the accumulator, the word counter, clamping and error logic.

## Test plan
- **Full frame, maximum counts:** 16 consecutive words of count 32 with `out_ready` = 1 → one cycle after the 16th word, `out_sum` = 512, `out_words` = 16, `out_over` = 1, `err_range` = 0.
- **Early close:** counts 5, 6, 7 with `in_last` on the third word → `out_sum` = 18, `out_words` = 3, `out_over` = 0. The next frame starts from 0.
- **Backpressure:** a frame closes with `out_ready` = 0 → `in_ready` = 0 and the result holds stable for 5 cycles. Raising `out_ready` consumes it, and `in_ready` returns to 1 in the same cycle.
- **Back-to-back close and consume:** a close coincides with a consume → the new result is loaded and `out_valid` stays 1 with no gap. Two frames of 16 × count 16 each report `out_sum` = 256, `out_over` = 1.
- **Out-of-range input:** `in_count` = 40 → accumulated as 32 and `err_range` = 1, which persists across later frames until `rst_n` is pulsed.
- **Reset mid-frame:** assert `rst_n` low after 7 accepted words → all outputs go to 0 immediately. After release, 16 words of count 1 produce `out_sum` = 16, `out_words` = 16.
